// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder/subtractor family).
package arith_pkg;

  localparam int unsigned DefaultW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } arith_state_e;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: diff = x - y - bin, with borrow-out.
module full_subtractor_1bit (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  always_comb begin
    diff_o = x_i ^ y_i ^ bin_i;
    bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor_4bit
  import arith_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  arith_state_e  state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;

  logic          fs_diff;
  logic          fs_bout;

  full_subtractor_1bit u_fs (
    .x_i   (sa_q[0]),
    .y_i   (sb_q[0]),
    .bin_i (br_q),
    .diff_o(fs_diff),
    .bout_o(fs_bout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        res_d = {fs_diff, res_q[W-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = fs_bout;
        if (cnt_q == CntLast) begin
          // Load outputs on the last bit so d/bout are already valid while done is high.
          d_d     = {fs_diff, res_q[W-1:1]};
          bout_d  = fs_bout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
    d     = d_q;
    bout  = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench for serial_subtractor_4bit: driver queues expectations, monitor checks on done.
module tb_serial_subtractor_4bit;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  serial_subtractor_4bit #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .ready(ready),
    .done (done),
    .d    (d),
    .bout (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e_mon;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] hold_d = '0;
  logic         hold_bout = 1'b0;
  logic         prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on every done; between dones the outputs must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1, expected no done (t=%0t)", $time);
        end else begin
          e_mon = sb_q.pop_front();
          check("d", int'(d), int'(e_mon.d));
          check("bout", int'(bout), int'(e_mon.bout));
          // done cycle index is W+1 counting the accept cycle as 0, i.e. W edges after accept.
          check("latency", cyc - e_mon.acc, int'(W));
          check("ready_in_done", int'(ready), 0);
          hold_d    = e_mon.d;
          hold_bout = e_mon.bout;
        end
      end else begin
        check("d_hold", int'(d), int'(hold_d));
        check("bout_hold", int'(bout), int'(hold_bout));
      end
      if (prev_done) check("ready_after_done", int'(ready), 1);
      prev_done = done;
    end
  end

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input bit push);
    exp_t e;
    wait_ready();
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.d    = ed;
      e.bout = eb;
      e.acc  = cyc;
      sb_q.push_back(e);
    end
    check("ready_fell", int'(ready), 0);
  endtask

  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       output logic [W-1:0] ed, output logic eb);
    logic [W:0] r;
    r  = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    ed = r[W-1:0];
    eb = r[W];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ed;
    logic         eb;
    exp_t         e;
    logic [W-1:0] va [4] = '{4'd9, 4'd14, 4'd2, 4'd15};
    logic [W-1:0] vb [4] = '{4'd3, 4'd7, 4'd5, 4'd0};
    logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] vd [4] = '{4'd6, 4'd6, 4'hD, 4'hE};
    logic         vo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_d", int'(d), 0);
    check("rst_bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary directed vectors
    do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b1);
    do_op(4'd15, 4'd15, 1'b0, 4'h0, 1'b0, 1'b1);

    // Starts during SHIFT and DONE must be ignored
    do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    for (int i = 0; i < int'(W) + 1; i++) begin
      @(posedge clk);
      #1;
      if (i < int'(W)) check("ready_busy", int'(ready), 0);
    end
    start = 1'b0;

    // Asynchronous reset mid-operation discards the partial result
    do_op(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    sb_q.delete();
    hold_d    = '0;
    hold_bout = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("arst_ready", int'(ready), 1);
    check("arst_done", int'(done), 0);
    check("arst_d", int'(d), 0);
    check("arst_bout", int'(bout), 0);
    @(negedge clk);
    prev_done = 1'b0;
    rst_n     = 1'b1;
    do_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b1);

    // start held high: one op per W+2 cycles, operand changes mid-op ignored
    wait_ready();
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a   = va[k];
      b   = vb[k];
      bin = vc[k];
      @(posedge clk);
      #1;
      e.d    = vd[k];
      e.bout = vo[k];
      e.acc  = cyc;
      sb_q.push_back(e);
      a   = ~va[k];
      b   = 4'd1;
      bin = ~vc[k];
      if (k < 3) begin
        repeat (W + 1) @(posedge clk);
        #1;
        check("held_start_period", int'(ready), 1);
      end
    end
    start = 1'b0;

    // Exhaustive sweep against the arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          model(W'(ia), W'(ib), 1'(ic), ed, eb);
          do_op(W'(ia), W'(ib), 1'(ic), ed, eb, 1'b1);
        end
      end
    end

    wait_ready();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
